monolith_perm_ctrl: RTL and testbench
=====================================

Name: monolith_perm_ctrl

Overview:
Round sequencer for the Monolith-31 permutation. It accepts one state vector through a valid/ready handshake and holds it in an internal state register. It iterates an external combinational round datapath (bars → bricks → concrete + round constants) once per cycle for NUM_ROUNDS+1 passes, then presents the permuted state through a valid/ready output handshake. It sits between the hash-level sponge logic and the round datapath built around the bars layer.

Parameters:
WORD_WIDTH, 31, bits per state word (field element mod 2^31-1)
STATE_SIZE, 16, words per state
BAR_OP_COUNT, 8, words processed by bars; passed through on dp_bars_cnt for datapath configuration
NUM_ROUNDS, 6, full rounds after the initial concrete pass

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input state valid
in_ready  out  1  controller can accept a state
in_state  in  STATE_SIZE x WORD_WIDTH  input state
out_valid  out  1  permuted state valid
out_ready  in  1  consumer accepts output
out_state  out  STATE_SIZE x WORD_WIDTH  permuted state (register output)
dp_state  out  STATE_SIZE x WORD_WIDTH  current state driven to round datapath (same register as out_state)
dp_round  out  $clog2(NUM_ROUNDS+1)  round index for datapath; 0 = initial concrete only
dp_bars_cnt  out  $clog2(STATE_SIZE+1)  constant BAR_OP_COUNT
dp_result  in  STATE_SIZE x WORD_WIDTH  combinational datapath result for dp_state/dp_round
busy  out  1  high in BUSY

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. Every register is cleared on the asserting edge of reset, independent of clk.
- States: IDLE, BUSY, DONE.
- Reset values: FSM = IDLE, state register = 0, round counter = 0. Outputs at reset: in_ready=1, out_valid=0, busy=0, dp_round=0, out_state=0.
- Output decode: in_ready = (FSM==IDLE); out_valid = (FSM==DONE); busy = (FSM==BUSY); dp_round = round counter.
- IDLE: on in_valid && in_ready, load state ← in_state, round ← 0, go to BUSY. in_state is ignored otherwise.
- BUSY, each cycle: state ← dp_result.
  - If round == NUM_ROUNDS, go to DONE and hold round.
  - Otherwise round ← round+1.
  - The controller spends exactly NUM_ROUNDS+1 cycles in BUSY.
- Latency: accepting edge at cycle 0 → out_valid high from cycle NUM_ROUNDS+2 (cycle 8 for defaults).
- DONE: state and round are frozen. out_state holds stable while out_valid && !out_ready. On out_ready, go to IDLE and reset round to 0. in_ready rises the next cycle, so there are no back-to-back accept/drain in the same cycle. Minimum initiation interval is NUM_ROUNDS+3 cycles.
- in_valid asserted outside IDLE: ignored, and the state is not captured. The upstream must hold in_valid until in_ready.
- dp_result is sampled only in BUSY. The datapath must settle within one clk period.
- Round counter must never exceed NUM_ROUNDS. No wrap-around is reachable.
- Reset mid-operation (BUSY or DONE): immediate return to IDLE. The in-flight state is discarded and out_valid drops asynchronously.
- No arithmetic is performed in the controller. Widths are passed unchanged.

Optional Feature:
MONOLITH_CTRL_CANON_CHECK_EN
- Defined:
  - On the load in IDLE, any in_state word equal to 2^31-1 (non-canonical zero) is stored as 0.
  - Adds output port err_noncanon (1 bit). It is sticky and set on any such load.
  - err_noncanon is cleared only by reset.
  - Checking is done in parallel over all STATE_SIZE words within the load cycle, with no added latency.
- Undefined: words are loaded verbatim, no err_noncanon port, no extra logic.

Decomposition:
- monolith_pkg holds:
  - constants WORD_WIDTH_C=31, STATE_SIZE_C=16, NUM_ROUNDS_C=6, MERSENNE_P=31'h7FFFFFFF
  - typedef word_t (logic [WORD_WIDTH-1:0]) and state_t (word_t [STATE_SIZE-1:0])
  - enum ctrl_state_e {IDLE, BUSY, DONE}
- The module shares the package with the bars, bricks and concrete layers.
- One natural sub-module: monolith_round_counter (load-zero, enable-increment, terminal-count flag at NUM_ROUNDS). Everything else stays inline.

Test Plan:
All scenarios use a stub datapath: dp_result[i] = dp_state[i] + dp_round + 1. Defaults apply.
1. Basic permutation: in_state[i]=i, in_valid for 1 cycle, out_ready=1 → out_valid at cycle 8 for exactly 1 cycle; out_state[i]=i+28; in_ready high again at cycle 9.
2. Output backpressure: out_ready=0 for 5 cycles after out_valid → out_valid and out_state (i+28) remain stable for all 5 cycles; in_ready=0; a new in_valid is not accepted.
3. Ignored input: pulse in_valid with in_state=all 0x1234 during BUSY → result unchanged (i+28); the pulse is not captured.
4. Reset mid-run: assert reset at round 3 asynchronously between edges → in_ready=1, busy=0, out_valid=0 immediately; a fresh input 0 then yields out_state[i]=28.
5. Back-to-back: two inputs A[i]=0 and B[i]=100 with in_valid held and out_ready=1 → outputs 28 and 128 with rising edges of out_valid 9 cycles apart.
6. With MONOLITH_CTRL_CANON_CHECK_EN: in_state[0]=0x7FFFFFFF → out_state[0]=28; err_noncanon=1 persists until reset. Without the macro, the stub sum yields 0x7FFFFFFF+28 truncated to 31 bits = 27.

Source files
------------

// File: rtl/monolith_pkg.sv
// Shared Monolith-31 types and constants used by the controller and the
// bars/bricks/concrete round layers.
package monolith_pkg;

  localparam int WORD_WIDTH_C   = 31;
  localparam int STATE_SIZE_C   = 16;
  localparam int BAR_OP_COUNT_C = 8;
  localparam int NUM_ROUNDS_C   = 6;

  localparam logic [WORD_WIDTH_C-1:0] MERSENNE_P = 31'h7FFFFFFF;

  typedef logic [WORD_WIDTH_C-1:0] word_t;
  typedef word_t [STATE_SIZE_C-1:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/monolith_round_counter.sv
// Round index for the permutation: cleared on load/drain, advances while
// enabled and saturates at NUM_ROUNDS, flagging the terminal round.
module monolith_round_counter #(
  parameter int NUM_ROUNDS = 6,
  parameter int CW         = $clog2(NUM_ROUNDS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] round,
  output logic          last
);

  assign last = (round == CW'(NUM_ROUNDS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round <= '0;
    end else if (clear) begin
      round <= '0;
    end else if (inc && !last) begin
      round <= round + CW'(1);
    end
  end

endmodule

// File: rtl/monolith_perm_ctrl.sv
// Monolith-31 round sequencer: load one state, iterate the external round
// datapath NUM_ROUNDS+1 times, present the result. Optional macro:
// MONOLITH_CTRL_CANON_CHECK_EN (canonicalises 2^31-1 words, adds err_noncanon).
module monolith_perm_ctrl
  import monolith_pkg::*;
#(
  parameter  int WORD_WIDTH   = WORD_WIDTH_C,
  parameter  int STATE_SIZE   = STATE_SIZE_C,
  parameter  int BAR_OP_COUNT = BAR_OP_COUNT_C,
  parameter  int NUM_ROUNDS   = NUM_ROUNDS_C,
  localparam int RW           = $clog2(NUM_ROUNDS + 1),
  localparam int BW           = $clog2(STATE_SIZE + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] in_state,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] out_state,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] dp_state,
  output logic [RW-1:0]                         dp_round,
  output logic [BW-1:0]                         dp_bars_cnt,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] dp_result,
  output logic                                  busy,
  output ctrl_state_e                           dbg_state
`ifdef MONOLITH_CTRL_CANON_CHECK_EN
  ,
  output logic                                  err_noncanon
`endif
);

  // Handshakes: a transfer happens on a clk edge where valid && ready; the
  // producer holds valid and data stable until then, and ready never waits on valid.
  ctrl_state_e state_q, state_n;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] st_q, load_val;
  logic accept, drain, round_last;

  assign accept = (state_q == IDLE) && in_valid;
  assign drain  = (state_q == DONE) && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_n = BUSY;
      BUSY:    if (round_last) state_n = DONE;
      DONE:    if (out_ready)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  monolith_round_counter #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .CW         (RW)
  ) u_round_counter (
    .clk   (clk),
    .reset (reset),
    .clear (accept || drain),
    .inc   (state_q == BUSY),
    .round (dp_round),
    .last  (round_last)
  );

`ifdef MONOLITH_CTRL_CANON_CHECK_EN
  logic [STATE_SIZE-1:0] nc_word;

  // 2^W-1 is the second encoding of zero in the Mersenne field.
  always_comb begin
    nc_word  = '0;
    load_val = in_state;
    for (int i = 0; i < STATE_SIZE; i++) begin
      nc_word[i] = (in_state[i] == {WORD_WIDTH{1'b1}});
      if (nc_word[i]) load_val[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_noncanon <= 1'b0;
    end else if (accept && (|nc_word)) begin
      err_noncanon <= 1'b1;
    end
  end
`else
  assign load_val = in_state;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= '0;
    end else if (accept) begin
      st_q <= load_val;
    end else if (state_q == BUSY) begin
      st_q <= dp_result;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q == BUSY);
  assign out_state   = st_q;
  assign dp_state    = st_q;
  assign dp_bars_cnt = BW'(BAR_OP_COUNT);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_monolith_perm_ctrl.sv
// Self-checking bench for monolith_perm_ctrl with a stub round datapath
// (dp_result[i] = dp_state[i] + dp_round + 1) and a closed-form reference model.
`timescale 1ns/1ps
module tb_monolith_perm_ctrl;
  import monolith_pkg::*;

  localparam int W  = WORD_WIDTH_C;
  localparam int S  = STATE_SIZE_C;
  localparam int N  = NUM_ROUNDS_C;
  localparam int SW = S * W;
  localparam int RW = $clog2(N + 1);
  localparam int BW = $clog2(S + 1);
  localparam logic [W-1:0] P = MERSENNE_P;
  // Stub adds r+1 in round r, r = 0..N, so the total offset is 1+2+..+(N+1).
  localparam longint ROUND_SUM = (N + 1) * (N + 2) / 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic [S-1:0][W-1:0] in_state = '0;
  logic [S-1:0][W-1:0] out_state, dp_state, dp_result;
  logic [RW-1:0] dp_round;
  logic [BW-1:0] dp_bars_cnt;
  ctrl_state_e dbg_state;
`ifdef MONOLITH_CTRL_CANON_CHECK_EN
  logic err_noncanon;
`endif

  monolith_perm_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_state    (in_state),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_state   (out_state),
    .dp_state    (dp_state),
    .dp_round    (dp_round),
    .dp_bars_cnt (dp_bars_cnt),
    .dp_result   (dp_result),
    .busy        (busy),
    .dbg_state   (dbg_state)
`ifdef MONOLITH_CTRL_CANON_CHECK_EN
    ,
    .err_noncanon(err_noncanon)
`endif
  );

  always_comb begin
    dp_result = '0;
    for (int i = 0; i < S; i++) dp_result[i] = dp_state[i] + W'(dp_round) + W'(1);
  end

  // ---------------- scoreboard / model ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [SW-1:0] exp_q[$];
  bit err_exp = 1'b0;

  task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [SW-1:0] model_perm(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    longint unsigned v;
    r = '0;
    for (int i = 0; i < S; i++) begin
      v = longint'(s[i*W +: W]);
`ifdef MONOLITH_CTRL_CANON_CHECK_EN
      if (s[i*W +: W] == P) v = 0;
`endif
      v = (v + ROUND_SUM) % (64'd1 << W);
      r[i*W +: W] = W'(v);
    end
    return r;
  endfunction

  task automatic note_load(input logic [SW-1:0] s);
`ifdef MONOLITH_CTRL_CANON_CHECK_EN
    for (int i = 0; i < S; i++) if (s[i*W +: W] == P) err_exp = 1'b1;
`endif
    exp_q.push_back(model_perm(s));
  endtask

  task automatic check_err(input string tag);
`ifdef MONOLITH_CTRL_CANON_CHECK_EN
    check(tag, err_noncanon, err_exp);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left #1 after a rising edge with the DUT in IDLE.
  task automatic run_one(input logic [SW-1:0] s, input int hold, input bit poke);
    int n;
    logic [SW-1:0] exp;
    in_state  = s;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    check("in_ready_idle", in_ready, 1);
    note_load(s);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = '0;
    check("busy_after_accept", busy, 1);
    n = 0;
    while (!out_valid && n < 40) begin
      check("dp_round", dp_round, n);
      if (poke && n == 2) begin
        in_valid = 1'b1;
        in_state = {S{31'h1234}};
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("latency", n, N + 1);
    check("round_done", dp_round, N);
    exp = exp_q.pop_front();
    check("out_state", out_state, exp);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_state = {S{W'($urandom)}};
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_out_state", out_state, exp);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    in_state  = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);
    check("drain_round", dp_round, 0);
    check_err("err_noncanon");
  endtask

  task automatic back_to_back(input logic [SW-1:0] a, input logic [SW-1:0] b);
    int rise_t[2];
    logic [SW-1:0] got[2];
    int rises;
    bit prev, b_pending;
    logic [SW-1:0] ea, eb;
    out_ready = 1'b1;
    in_state  = a;
    in_valid  = 1'b1;
    check("b2b_in_ready", in_ready, 1);
    note_load(a);
    @(posedge clk); #1;
    in_state  = b;
    rises     = 0;
    prev      = 1'b0;
    b_pending = 1'b0;
    rise_t    = '{0, 0};
    got       = '{'0, '0};
    for (int t = 1; t <= 30; t++) begin
      @(posedge clk); #1;
      if (b_pending) begin
        in_valid  = 1'b0;
        b_pending = 1'b0;
      end
      if (in_valid && in_ready) begin
        b_pending = 1'b1;
        note_load(b);
      end
      if (out_valid && !prev && rises < 2) begin
        rise_t[rises] = t;
        got[rises]    = out_state;
        rises++;
      end
      prev = out_valid;
    end
    in_valid = 1'b0;
    in_state = '0;
    check("b2b_rises", rises, 2);
    ea = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    eb = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    check("b2b_out_a", got[0], ea);
    check("b2b_out_b", got[1], eb);
    check("b2b_spacing", rise_t[1] - rise_t[0], N + 3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [SW-1:0] s;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_dp_round", dp_round, 0);
    check("rst_out_state", out_state, 0);
    check("rst_bars_cnt", dp_bars_cnt, BAR_OP_COUNT_C);
    check("rst_dbg_state", dbg_state, IDLE);
    check_err("rst_err");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // basic, backpressure, ignored input
    for (int i = 0; i < S; i++) s[i*W +: W] = W'(i);
    run_one(s, 0, 1'b0);
    run_one(s, 5, 1'b0);
    run_one(s, 0, 1'b1);

    // asynchronous reset in the middle of round 3
    in_state  = '0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid_round", dp_round, 3);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_round", dp_round, 0);
    err_exp = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    run_one('0, 0, 1'b0);

    // back-to-back with in_valid held
    s = '0;
    for (int i = 0; i < S; i++) s[i*W +: W] = W'(100);
    back_to_back('0, s);

    // non-canonical word 0
    for (int i = 0; i < S; i++) s[i*W +: W] = W'(i);
    s[0 +: W] = P;
    run_one(s, 1, 1'b0);
    run_one('0, 0, 1'b0);

    // randomized traffic
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < S; i++) begin
        s[i*W +: W] = W'($urandom);
        if ($urandom_range(0, 7) == 0) s[i*W +: W] = P;
      end
      run_one(s, int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)));
    end

    // reset clears the sticky flag
    @(negedge clk);
    reset = 1'b1;
    err_exp = 1'b0;
    #1;
    check_err("err_after_reset");
    check("final_rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
